cim_mem_arbiter: RTL and testbench
==================================

Name: cim_mem_arbiter

Overview:
- Shares one CIM single-port memory (intermediate-results or params instance) between the three requesters: BUS_FSM (index 0), LOGIC_FSM (index 1) and MAC (index 2).
- Arbitrates round-robin, one access per cycle, with an optional locked burst capped in length.
- Drives the memory's one-hot read/write source vectors, address and write data.
- Returns a per-requester read-valid pulse aligned with the memory's registered read data.
- One instance sits between the requesters and each memory instance.

Parameters:
- N_REQ, 3, number of requesters; index = BUS_FSM/LOGIC_FSM/MAC; fixed at 3.
- ADDR_W, 10, memory address width.
- DATA_W, N_STORAGE, data word width.
- MAX_BURST, 8, max consecutive grants to a locked owner; range 1..255.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- req  input  N_REQ  per-requester access request
- req_wen  input  N_REQ  1 = write, 0 = read, per requester
- req_lock  input  N_REQ  request burst lock, per requester
- req_addr  input  N_REQ x ADDR_W  per-requester address
- req_wdata  input  N_REQ x DATA_W  per-requester write data
- gnt  output  N_REQ  one-hot grant; combinational; access performed this cycle
- rvalid  output  N_REQ  one-hot; mem_rdata valid for that requester
- rdata  output  DATA_W  pass-through of mem_rdata
- mem_read_req_src  output  N_REQ  one-hot read source to memory
- mem_write_req_src  output  N_REQ  one-hot write source to memory
- mem_addr  output  ADDR_W  address to memory
- mem_wdata  output  DATA_W  write data to memory
- mem_rdata  input  DATA_W  memory registered read data
- err_mac_write  output  1  sticky: MAC attempted a write

Behaviour:
- Reset values:
  - gnt = 0, rvalid = 0, mem_*_req_src = 0.
  - mem_addr = 0, mem_wdata = 0 (via hold registers).
  - err_mac_write = 0, rr_ptr = 0, state = ARB, burst_cnt = 0.
- Handshake:
  - Requester holds req/wen/addr/wdata stable until it sees gnt.
  - Access completes in the gnt cycle.
  - Requester may keep req high for back-to-back accesses.
- State ARB:
  - Grant the first asserted req scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - After granting i: rr_ptr <= (i+1) mod 3.
  - If req_lock[i] is set and MAX_BURST > 1: state <= LOCKED, owner <= i, burst_cnt <= 1.
- State LOCKED:
  - Grant the owner only, while req[owner] && req_lock[owner] && burst_cnt < MAX_BURST; burst_cnt++.
  - Otherwise, in the same cycle: state <= ARB, burst_cnt <= 0, and arbitrate as in ARB with the owner excluded (forced release). No idle cycle.
  - rr_ptr is not updated while LOCKED.
- Memory drive, when i is granted:
  - mem_write_req_src[i] = req_wen[i]; mem_read_req_src[i] = !req_wen[i].
  - mem_addr = req_addr[i]; mem_wdata = req_wdata[i].
  - Addr and wdata are captured into hold registers.
- No grant: both src vectors = 0; mem_addr/mem_wdata hold the last granted values.
- MAC write (req[2] && req_wen[2] when MAC would be granted):
  - gnt[2] asserted (request consumed) but mem_write_req_src = 0.
  - err_mac_write <= 1, sticky until rst.
- Read return:
  - rvalid[i] registered; high exactly one cycle after a read grant to i.
  - rdata = mem_rdata.
  - Back-to-back reads give back-to-back rvalid pulses.
- At most one bit set across gnt, across the two src vectors combined, and across rvalid in any cycle.
- Reset mid-burst or mid-read: immediate return to ARB; rvalid cleared; the pending read response is dropped.

Test Plan:
- Single LOGIC read at addr 0x05 (mem[5] = 0xAB) -> gnt = 3'b010 same cycle, mem_read_req_src = 3'b010, mem_addr = 5; next cycle rvalid = 3'b010, rdata = 0xAB.
- All three req held continuously, no lock, after reset -> grant order BUS, LOGIC, MAC, BUS, ... one per cycle; rvalid follows each read by 1 cycle.
- BUS lock burst of 20 writes, MAX_BURST = 8, LOGIC also requesting -> 8 BUS grants, then LOGIC granted on the 9th cycle, then BUS resumes its burst.
- BUS lock dropped after 3 grants -> ARB in the same cycle, LOGIC granted immediately, no bubble.
- MAC write request -> gnt[2] = 1, both src vectors = 0, err_mac_write = 1 and stays 1; a later MAC read works normally.
- rst asserted for 1 cycle mid-burst with a read outstanding -> rvalid = 0, gnt = 0 during rst; after rst, first grant goes to BUS (rr_ptr = 0).

Source files
------------

// File: rtl/cim_mem_arbiter.sv
// Round-robin arbiter sharing one CIM single-port memory between
// BUS_FSM (0), LOGIC_FSM (1) and MAC (2), with capped locked bursts,
// one-hot memory source drive and a registered per-requester read-valid.
module cim_mem_arbiter #(
   parameter int N_REQ     = 3,
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_wen,
   input  logic [N_REQ-1:0]          req_lock,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic [N_REQ-1:0]          mem_read_req_src,
   output logic [N_REQ-1:0]          mem_write_req_src,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      err_mac_write
);

   localparam int               IDX_W     = $clog2(N_REQ);
   localparam logic [IDX_W-1:0] MAC_IDX   = IDX_W'(2);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
   localparam logic [7:0]       BURST_MAX = 8'(MAX_BURST);

   typedef enum logic {
      ARB,
      LOCKED
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  owner;
   logic [7:0]        burst_cnt;
   logic [ADDR_W-1:0] addr_hold;
   logic [DATA_W-1:0] wdata_hold;

   logic [IDX_W-1:0]  sel;
   logic [IDX_W-1:0]  cand;
   logic              sel_valid;
   logic              hold_owner;
   logic              sel_wen;
   logic              mac_wr;

   assign rdata = mem_rdata;

   // Pick this cycle's grantee: the locked owner while its burst may continue,
   // otherwise a round-robin scan from rr_ptr; a forced release skips the owner
   // so another requester is served in the same cycle.
   always_comb begin
      hold_owner = 1'b0;
      sel_valid  = 1'b0;
      sel        = '0;
      cand       = '0;
      if (!rst) begin
         if (state == LOCKED && req[owner] && req_lock[owner] && burst_cnt < BURST_MAX) begin
            hold_owner = 1'b1;
            sel_valid  = 1'b1;
            sel        = owner;
         end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
               cand = IDX_W'((rr_ptr + k) % N_REQ);
               if (!sel_valid && req[cand] && !(state == LOCKED && cand == owner)) begin
                  sel_valid = 1'b1;
                  sel       = cand;
               end
            end
         end
      end
   end

   // Drive grant and memory interface; MAC writes are consumed but never reach the memory.
   always_comb begin
      sel_wen           = req_wen[sel];
      mac_wr            = sel_valid && sel_wen && (sel == MAC_IDX);
      gnt               = '0;
      mem_read_req_src  = '0;
      mem_write_req_src = '0;
      mem_addr          = addr_hold;
      mem_wdata         = wdata_hold;
      if (sel_valid) begin
         gnt[sel]               = 1'b1;
         mem_read_req_src[sel]  = !sel_wen;
         mem_write_req_src[sel] = sel_wen && !mac_wr;
         mem_addr               = req_addr[32'(sel)*ADDR_W +: ADDR_W];
         mem_wdata              = req_wdata[32'(sel)*DATA_W +: DATA_W];
      end
   end

   // Arbitration state, burst accounting, hold registers, read-valid and MAC-write error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ARB;
         rr_ptr        <= '0;
         owner         <= '0;
         burst_cnt     <= '0;
         addr_hold     <= '0;
         wdata_hold    <= '0;
         rvalid        <= '0;
         err_mac_write <= 1'b0;
      end else begin
         rvalid <= mem_read_req_src;
         if (mac_wr) begin
            err_mac_write <= 1'b1;
         end
         if (sel_valid) begin
            addr_hold  <= mem_addr;
            wdata_hold <= mem_wdata;
         end
         if (hold_owner) begin
            burst_cnt <= burst_cnt + 8'd1;
         end else begin
            if (state == LOCKED) begin
               state     <= ARB;
               burst_cnt <= '0;
            end
            // A grant made on release may itself open a new burst.
            if (sel_valid) begin
               rr_ptr <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
               if (req_lock[sel] && MAX_BURST > 1) begin
                  state     <= LOCKED;
                  owner     <= sel;
                  burst_cnt <= 8'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_cim_mem_arbiter.sv
// Directed table-driven bench for cim_mem_arbiter with a small
// registered-read memory model behind the arbiter.
module tb_cim_mem_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req;
   logic [2:0]  req_wen;
   logic [2:0]  req_lock;
   logic [29:0] req_addr;
   logic [47:0] req_wdata;
   logic [2:0]  gnt;
   logic [2:0]  rvalid;
   logic [15:0] rdata;
   logic [2:0]  mem_read_req_src;
   logic [2:0]  mem_write_req_src;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        err_mac_write;

   int n_tests = 0;
   int n_fail  = 0;

   cim_mem_arbiter #(
      .N_REQ(3),
      .ADDR_W(10),
      .DATA_W(16),
      .MAX_BURST(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .req_wen(req_wen),
      .req_lock(req_lock),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .gnt(gnt),
      .rvalid(rvalid),
      .rdata(rdata),
      .mem_read_req_src(mem_read_req_src),
      .mem_write_req_src(mem_write_req_src),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .err_mac_write(err_mac_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port memory with registered read data.
   logic [15:0] mem [0:1023];
   always @(posedge clk) begin
      if (|mem_write_req_src) mem[mem_addr] <= mem_wdata;
      if (|mem_read_req_src)  mem_rdata <= mem[mem_addr];
   end

   typedef struct {
      logic [2:0]  req;
      logic [2:0]  wen;
      logic [2:0]  lock;
      logic [2:0]  gnt;
      logic [2:0]  rsrc;
      logic [2:0]  wsrc;
      logic [2:0]  rv;
      logic [9:0]  addr;
      logic [15:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [2:0] r, w, l, g, rs, ws, rv,
                      input logic [9:0] a, input logic [15:0] rd, input logic e);
      vec_t v;
      v.req = r; v.wen = w; v.lock = l; v.gnt = g; v.rsrc = rs; v.wsrc = ws;
      v.rv = rv; v.addr = a; v.rdata = rd; v.err = e;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] r, w, l);
      req = r; req_wen = w; req_lock = l;
   endtask

   initial begin
      rst       = 1'b1;
      req       = '0;
      req_wen   = '0;
      req_lock  = '0;
      // addresses: MAC 0x020, LOGIC 0x005, BUS 0x010
      req_addr  = {10'h020, 10'h005, 10'h010};
      req_wdata = {16'h3333, 16'h2222, 16'h1111};
      mem[10'h005] <= 16'h00AB;
      mem[10'h010] <= 16'h0011;
      mem[10'h020] <= 16'h0022;

      // req, wen, lock | gnt, rd_src, wr_src, rvalid | addr, rdata, err
      add(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 10'h000, 16'h0000, 1'b0);
      add(3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 10'h005, 16'h0000, 1'b0);
      add(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 10'h005, 16'h00AB, 1'b0);
      add(3'b111, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 10'h020, 16'h0000, 1'b0);
      add(3'b111, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b100, 10'h010, 16'h0022, 1'b0);
      add(3'b111, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b001, 10'h005, 16'h0011, 1'b0);
      add(3'b111, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b010, 10'h020, 16'h00AB, 1'b0);
      add(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 10'h020, 16'h0022, 1'b0);
      // BUS locked write burst with LOGIC waiting: 8 BUS grants, then LOGIC
      for (int k = 0; k < 8; k++)
         add(3'b011, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000, 10'h010, 16'h0000, 1'b0);
      add(3'b011, 3'b001, 3'b001, 3'b010, 3'b010, 3'b000, 3'b000, 10'h005, 16'h0000, 1'b0);
      add(3'b011, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 3'b010, 10'h010, 16'h00AB, 1'b0);
      add(3'b011, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000, 10'h010, 16'h0000, 1'b0);
      add(3'b011, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000, 10'h010, 16'h0000, 1'b0);
      // lock dropped after 3 grants: LOGIC served in the same cycle
      add(3'b011, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 10'h005, 16'h0000, 1'b0);
      add(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 10'h005, 16'h00AB, 1'b0);
      // MAC write: consumed, no memory write, sticky error
      add(3'b100, 3'b100, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 10'h020, 16'h0000, 1'b0);
      add(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 10'h020, 16'h0000, 1'b1);
      add(3'b100, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 10'h020, 16'h0000, 1'b1);
      add(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 10'h020, 16'h0022, 1'b1);

      // reset state
      @(negedge clk);
      check("reset gnt", gnt, 3'b000);
      check("reset rvalid", rvalid, 3'b000);
      check("reset src", {mem_write_req_src, mem_read_req_src}, 6'b0);
      check("reset mem_addr", mem_addr, 10'h000);
      check("reset mem_wdata", mem_wdata, 16'h0000);
      check("reset err", err_mac_write, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         drive(vecs[i].req, vecs[i].wen, vecs[i].lock);
         @(negedge clk);
         check($sformatf("row%0d gnt", i), gnt, vecs[i].gnt);
         check($sformatf("row%0d rd_src", i), mem_read_req_src, vecs[i].rsrc);
         check($sformatf("row%0d wr_src", i), mem_write_req_src, vecs[i].wsrc);
         check($sformatf("row%0d rvalid", i), rvalid, vecs[i].rv);
         check($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].addr);
         check($sformatf("row%0d err", i), err_mac_write, vecs[i].err);
         if (vecs[i].rv != 3'b000)
            check($sformatf("row%0d rdata", i), rdata, vecs[i].rdata);
      end

      // Reset in the middle of a locked BUS read burst with a read outstanding.
      @(posedge clk); #1 drive(3'b001, 3'b000, 3'b001);
      @(negedge clk);
      check("burstA gnt", gnt, 3'b001);
      @(posedge clk); #1;
      @(negedge clk);
      check("burstB gnt", gnt, 3'b001);
      check("burstB rvalid", rvalid, 3'b001);
      check("burstB rdata", rdata, 16'h1111);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("in-rst gnt", gnt, 3'b000);
      check("in-rst rvalid", rvalid, 3'b000);
      check("in-rst rd_src", mem_read_req_src, 3'b000);
      check("in-rst mem_addr", mem_addr, 10'h000);
      check("in-rst err", err_mac_write, 1'b0);
      @(posedge clk); #1 rst = 1'b0; drive(3'b111, 3'b000, 3'b000);
      @(negedge clk);
      check("post-rst gnt0", gnt, 3'b001);
      check("post-rst rvalid0", rvalid, 3'b000);
      @(posedge clk); #1;
      @(negedge clk);
      check("post-rst gnt1", gnt, 3'b010);
      check("post-rst rvalid1", rvalid, 3'b001);
      check("post-rst rdata1", rdata, 16'h1111);
      @(posedge clk); #1;
      @(negedge clk);
      check("post-rst gnt2", gnt, 3'b100);
      check("post-rst rvalid2", rvalid, 3'b010);
      check("post-rst rdata2", rdata, 16'h00AB);
      @(posedge clk); #1 drive(3'b000, 3'b000, 3'b000);
      @(negedge clk);
      check("post-rst gnt3", gnt, 3'b000);
      check("post-rst rvalid3", rvalid, 3'b100);
      check("post-rst rdata3", rdata, 16'h0022);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
